// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes, BFM state encoding and a
// slave address-map descriptor used by benches.
package axi4l_pkg;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } axi4l_state_e;

    typedef struct packed {
        logic [63:0] base_addr;
        logic [63:0] base_mask;
        int unsigned addr_width;
        int unsigned data_width;
    } axi4l_config_t;

    function automatic logic addr_hit(input axi4l_config_t cfg, input logic [63:0] addr);
        return (addr & cfg.base_mask) == cfg.base_addr;
    endfunction

endpackage

// File: rtl/axi4l_bfm_if.sv
// AXI4-Lite bus bundle; master drives requests, slave drives ready/responses.
interface axi4l_bfm_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_bfm.sv
// Single-outstanding AXI4-Lite master: turns one command into one bus
// transaction and reports the response with a one-cycle rsp_valid pulse.
module axi4l_bfm
    import axi4l_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axi4l_bfm_if.master             axi
);

    axi4l_state_e state;
    logic         aw_done;
    logic         w_done;

    assign axi.awprot = 3'b000;
    assign axi.arprot = 3'b000;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= OKAY;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.bready  <= 1'b0;
            axi.rready  <= 1'b0;
            axi.awaddr  <= '0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.araddr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_write) begin
                            axi.awaddr <= cmd_addr;
                            axi.wdata  <= cmd_wdata;
                            axi.wstrb  <= cmd_wstrb;
                            state      <= WRITE;
                        end else begin
                            axi.araddr <= cmd_addr;
                            state      <= RADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    // First WRITE cycle raises both valids; afterwards each
                    // channel retires on its own handshake.
                    if (!aw_done && !w_done && !axi.awvalid && !axi.wvalid) begin
                        axi.awvalid <= 1'b1;
                        axi.wvalid  <= 1'b1;
                    end else begin
                        if (axi.awvalid && axi.awready) begin
                            axi.awvalid <= 1'b0;
                            aw_done     <= 1'b1;
                        end
                        if (axi.wvalid && axi.wready) begin
                            axi.wvalid <= 1'b0;
                            w_done     <= 1'b1;
                        end
                        if ((aw_done || (axi.awvalid && axi.awready)) &&
                            (w_done  || (axi.wvalid  && axi.wready))) begin
                            axi.bready <= 1'b1;
                            state      <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        rsp_rdata  <= '0;
                        rsp_resp   <= axi.bresp;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                RADDR: begin
                    if (!axi.arvalid) begin
                        axi.arvalid <= 1'b1;
                    end else if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi.rvalid) begin
                        axi.rready <= 1'b0;
                        rsp_rdata  <= axi.rdata;
                        rsp_resp   <= axi.rresp;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_bfm.sv
// Directed bench for axi4l_bfm: behavioural AXI4-Lite slave with a small RAM,
// expected responses queued per command and checked when rsp_valid pulses.
module tb_axi4l_bfm;
    import axi4l_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          aclk;
    logic          aresetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    axi4l_bfm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4l_bfm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    axi4l_config_t cfg;
    logic [31:0]   mem [0:15];
    int unsigned   aw_delay;
    int unsigned   aw_cnt;
    logic          r_stall;
    logic          aw_got, w_got, b_pend, r_pend;
    logic [31:0]   aw_a, w_d, r_d;
    logic [3:0]    w_s;
    logic [1:0]    b_r, r_r;
    logic          ag, wg;
    logic [31:0]   a_n, d_n;
    logic [3:0]    s_n;

    assign bus.awready = (aw_cnt >= aw_delay);
    assign bus.wready  = 1'b1;
    assign bus.arready = 1'b1;
    assign bus.bvalid  = b_pend;
    assign bus.bresp   = b_r;
    assign bus.rvalid  = r_pend && !r_stall;
    assign bus.rdata   = r_d;
    assign bus.rresp   = r_r;

    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_cnt <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_pend <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            ag = aw_got; wg = w_got; a_n = aw_a; d_n = w_d; s_n = w_s;
            if (bus.awvalid) begin
                if (bus.awready) begin
                    ag = 1'b1; a_n = bus.awaddr; aw_cnt <= 0;
                end else begin
                    aw_cnt <= aw_cnt + 1;
                end
            end
            if (bus.wvalid && bus.wready) begin
                wg = 1'b1; d_n = bus.wdata; s_n = bus.wstrb;
            end
            if (ag && wg) begin
                if (addr_hit(cfg, {32'd0, a_n})) begin
                    for (int b = 0; b < 4; b++)
                        if (s_n[b]) mem[a_n[5:2]][8*b +: 8] <= d_n[8*b +: 8];
                    b_r <= OKAY;
                end else begin
                    b_r <= SLVERR;
                end
                b_pend <= 1'b1;
                ag = 1'b0; wg = 1'b0;
            end else if (b_pend && bus.bready) begin
                b_pend <= 1'b0;
            end
            aw_got <= ag; w_got <= wg; aw_a <= a_n; w_d <= d_n; w_s <= s_n;
            if (bus.arvalid && bus.arready) begin
                r_pend <= 1'b1;
                if (addr_hit(cfg, {32'd0, bus.araddr})) begin
                    r_d <= mem[bus.araddr[5:2]]; r_r <= OKAY;
                end else begin
                    r_d <= '0; r_r <= SLVERR;
                end
            end else if (bus.rvalid && bus.rready) begin
                r_pend <= 1'b0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int unsigned stab_err, prot_err, aw_stall, w_hi, rsp_cnt;
    logic        p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    initial begin
        stab_err = 0; prot_err = 0; aw_stall = 0; w_hi = 0; rsp_cnt = 0;
        p_aw = 0; p_w = 0; p_ar = 0;
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (p_aw && !(bus.awvalid && bus.awaddr == p_awaddr)) stab_err++;
            if (p_w && !(bus.wvalid && bus.wdata == p_wdata && bus.wstrb == p_wstrb)) stab_err++;
            if (p_ar && !(bus.arvalid && bus.araddr == p_araddr)) stab_err++;
            if (bus.awvalid && bus.awprot != 3'b000) prot_err++;
            if (bus.arvalid && bus.arprot != 3'b000) prot_err++;
            if (bus.awvalid && !bus.awready) aw_stall++;
            if (bus.wvalid) w_hi++;
            if (rsp_valid) rsp_cnt++;
        end
        p_aw = aresetn && bus.awvalid && !bus.awready;
        p_w  = aresetn && bus.wvalid && !bus.wready;
        p_ar = aresetn && bus.arvalid && !bus.arready;
        p_awaddr = bus.awaddr; p_wdata = bus.wdata; p_wstrb = bus.wstrb; p_araddr = bus.araddr;
    end

    // ---------------- checking ----------------
    int unsigned total, bad;
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        int unsigned n;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_accept", {63'd0, cmd_ready}, 64'd1);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_d,
                           input logic [1:0] exp_r, output int unsigned lat);
        logic [33:0] e;
        exp_q.push_back({exp_d, exp_r});
        issue(wr, addr, data, strb);
        lat = 0;
        do begin
            @(negedge aclk);
            lat++;
        end while (!rsp_valid && lat < 50);
        check("rsp_seen", {63'd0, rsp_valid}, 64'd1);
        if (rsp_valid) begin
            check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e[33:2]});
                check("rsp_resp", {62'd0, rsp_resp}, {62'd0, e[1:0]});
            end
        end
        @(negedge aclk);
        check("rsp_pulse_1cyc", {63'd0, rsp_valid}, 64'd0);
    endtask

    int unsigned lat, base_stall, base_w, base_rsp, n;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; bad = 0;
        cfg = '{base_addr: 64'h0, base_mask: 64'hFFFF_FFFF_FFFF_FFC0, addr_width: AW, data_width: DW};
        for (int i = 0; i < 16; i++) mem[i] = '0;
        aw_delay = 0; r_stall = 1'b0;
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_valids", {59'd0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("rst_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1 check("cmd_ready_after_rel", {63'd0, cmd_ready}, 64'd1);

        // loopback and zero-wait latency
        run_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, OKAY, lat);
        check("wr_latency", lat, 64'd4);
        run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, OKAY, lat);
        check("rd_latency", lat, 64'd4);

        // AW ready skewed three cycles behind W
        aw_delay = 3;
        base_stall = aw_stall; base_w = w_hi; base_rsp = rsp_cnt;
        run_cmd(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 32'h0, OKAY, lat);
        repeat (3) @(negedge aclk);
        check("skew_aw_stall", aw_stall - base_stall, 64'd3);
        check("skew_w_cycles", w_hi - base_w, 64'd1);
        check("skew_one_rsp", rsp_cnt - base_rsp, 64'd1);
        aw_delay = 0;
        run_cmd(1'b0, 32'h14, 32'h0, 4'h0, 32'hCAFEF00D, OKAY, lat);

        // error responses complete normally
        run_cmd(1'b1, 32'h8000_0000, 32'h12345678, 4'hF, 32'h0, SLVERR, lat);
        check("err_back_idle", {63'd0, cmd_ready}, 64'd1);
        run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, OKAY, lat);
        run_cmd(1'b0, 32'h8000_0040, 32'h0, 4'h0, 32'h0, SLVERR, lat);

        // partial strobe merge
        run_cmd(1'b1, 32'h18, 32'hFFFFFFFF, 4'hF, 32'h0, OKAY, lat);
        run_cmd(1'b1, 32'h18, 32'h11223344, 4'h3, 32'h0, OKAY, lat);
        run_cmd(1'b0, 32'h18, 32'h0, 4'h0, 32'hFFFF3344, OKAY, lat);

        // reset while waiting in RDATA
        r_stall = 1'b1;
        base_rsp = rsp_cnt;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        n = 0;
        while (!bus.rready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("reached_rdata", {63'd0, bus.rready}, 64'd1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1 check("midrst_valids", {61'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 64'd0);
        check("midrst_rready", {63'd0, bus.rready}, 64'd0);
        check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        r_stall = 1'b0;
        @(posedge aclk);
        #1 check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        repeat (6) @(negedge aclk);
        check("midrst_no_rsp", rsp_cnt - base_rsp, 64'd0);
        run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, OKAY, lat);
        check("post_rst_latency", lat, 64'd4);

        check("valid_stability", stab_err, 64'd0);
        check("prot_zero", prot_err, 64'd0);
        check("sb_drained", exp_q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
